// File: rtl/kypd_note_sequencer.sv
// Key-stream sequencer sitting between the keypad scanner and the decoder.
// IDLE passes the live key through, RECORD stores timed {code, duration}
// events in a small buffer, and PLAY replays that buffer once or looping.
// Durations are counted in tick_i strobes; an entry code with bit 4 set is a rest.
module kypd_note_sequencer #(
    parameter int DEPTH = 32,
    parameter int DUR_W = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     tick_i,
    input  logic                     key_valid_i,
    input  logic [3:0]               key_value_i,
    input  logic                     rec_i,
    input  logic                     play_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic [3:0]               key_value_o,
    output logic                     mute_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     busy_o
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam logic [4:0]       REST_CODE = 5'b1_0000;
    localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};
    localparam logic [DUR_W-1:0] DUR_ZERO  = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [ADDR_W:0]  CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  CNT_LAST  = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    // Event buffer: code bit 4 marks a rest, low nibble is the key code.
    logic [4:0]        code_mem_r [DEPTH];
    logic [DUR_W-1:0]  dur_mem_r  [DEPTH];

    state_t            state_r;
    logic [3:0]        key_r;
    logic              mute_r;
    logic [ADDR_W:0]   count_r;
    logic              full_r;
    logic              busy_r;
    logic              armed_r;
    logic [4:0]        open_code_r;
    logic [DUR_W-1:0]  dur_r;
    logic [ADDR_W-1:0] idx_r;
    logic [DUR_W-1:0]  rem_r;

    logic [4:0]        eff_s;
    logic [DUR_W-1:0]  dur_inc_s;
    logic              changed_s;
    logic              sat_s;
    logic              wr_en_s;
    logic              last_s;
    logic [ADDR_W-1:0] nxt_idx_s;
    logic [4:0]        nxt_code_s;
    logic [DUR_W-1:0]  nxt_dur_s;

    // Effective key, open-event bookkeeping, write decision and next playback entry.
    always_comb begin
        eff_s      = key_valid_i ? {1'b0, key_value_i} : REST_CODE;
        // A tick in the same cycle as a key change still belongs to the closing event.
        dur_inc_s  = dur_r + DUR_W'(tick_i);
        changed_s  = armed_r && (eff_s != open_code_r);
        sat_s      = armed_r && (dur_inc_s == DUR_MAX);
        wr_en_s    = 1'b0;
        if (state_r == ST_RECORD) begin
            if (stop_i) begin
                wr_en_s = armed_r && (dur_inc_s != DUR_ZERO) && !full_r;
            end else begin
                // Zero-length events (key glitches between ticks) are dropped.
                wr_en_s = sat_s || (changed_s && (dur_inc_s != DUR_ZERO));
            end
        end else begin
            wr_en_s = 1'b0;
        end
        last_s     = (({1'b0, idx_r} + CNT_ONE) == count_r);
        nxt_idx_s  = last_s ? IDX_ZERO : (idx_r + IDX_ONE);
        nxt_code_s = code_mem_r[nxt_idx_s];
        nxt_dur_s  = dur_mem_r[nxt_idx_s];
    end

    // Buffer write port; contents are don't-care until count_r covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            code_mem_r[count_r[ADDR_W-1:0]] <= open_code_r;
            dur_mem_r[count_r[ADDR_W-1:0]]  <= dur_inc_s;
        end
    end

    // Mode FSM with registered key/mute/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            key_r       <= 4'h0;
            mute_r      <= 1'b1;
            count_r     <= CNT_ZERO;
            full_r      <= 1'b0;
            busy_r      <= 1'b0;
            armed_r     <= 1'b0;
            open_code_r <= REST_CODE;
            dur_r       <= DUR_ZERO;
            idx_r       <= IDX_ZERO;
            rem_r       <= DUR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stop_i) begin
                        key_r  <= eff_s[3:0];
                        mute_r <= eff_s[4];
                    end else if (rec_i) begin
                        state_r <= ST_RECORD;
                        busy_r  <= 1'b1;
                        count_r <= CNT_ZERO;
                        full_r  <= 1'b0;
                        armed_r <= 1'b0;
                        dur_r   <= DUR_ZERO;
                        key_r   <= eff_s[3:0];
                        mute_r  <= eff_s[4];
                    end else if (play_i && (count_r != CNT_ZERO)) begin
                        state_r <= ST_PLAY;
                        busy_r  <= 1'b1;
                        idx_r   <= IDX_ZERO;
                        rem_r   <= dur_mem_r[IDX_ZERO];
                        key_r   <= code_mem_r[IDX_ZERO][3:0];
                        mute_r  <= code_mem_r[IDX_ZERO][4];
                    end else begin
                        key_r  <= eff_s[3:0];
                        mute_r <= eff_s[4];
                    end
                end
                ST_RECORD: begin
                    key_r  <= eff_s[3:0];
                    mute_r <= eff_s[4];
                    if (wr_en_s) begin
                        count_r <= count_r + CNT_ONE;
                        if (count_r == CNT_LAST) begin
                            full_r <= 1'b1;
                        end
                    end
                    if (stop_i || (wr_en_s && (count_r == CNT_LAST))) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        armed_r <= 1'b0;
                        dur_r   <= DUR_ZERO;
                    end else if (!armed_r) begin
                        // Leading rest is not recorded: wait for the first press.
                        if (key_valid_i) begin
                            armed_r     <= 1'b1;
                            open_code_r <= eff_s;
                            dur_r       <= DUR_ZERO;
                        end
                    end else if (changed_s) begin
                        open_code_r <= eff_s;
                        dur_r       <= DUR_ZERO;
                    end else if (sat_s) begin
                        // Saturated event was written; continue same code from zero.
                        dur_r <= DUR_ZERO;
                    end else begin
                        dur_r <= dur_inc_s;
                    end
                end
                ST_PLAY: begin
                    if (stop_i) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        key_r   <= eff_s[3:0];
                        mute_r  <= eff_s[4];
                    end else if (tick_i) begin
                        if (rem_r == DUR_ONE) begin
                            if (last_s && !loop_i) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                                key_r   <= eff_s[3:0];
                                mute_r  <= eff_s[4];
                            end else begin
                                idx_r  <= nxt_idx_s;
                                rem_r  <= nxt_dur_s;
                                key_r  <= nxt_code_s[3:0];
                                mute_r <= nxt_code_s[4];
                            end
                        end else begin
                            rem_r <= rem_r - DUR_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    key_r   <= eff_s[3:0];
                    mute_r  <= eff_s[4];
                end
            endcase
        end
    end

    assign key_value_o = key_r;
    assign mute_o      = mute_r;
    assign state_o     = state_r;
    assign count_o     = count_r;
    assign full_o      = full_r;
    assign busy_o      = busy_r;

endmodule

// File: doc/kypd_note_sequencer.md
Name: kypd_note_sequencer

Overview:
- Sequences the key stream into the keypad decoder and divider datapath.
- Three modes: live passthrough (IDLE); RECORD captures timed key events into an internal buffer; PLAY replays the buffer to the decoder, once or looping.
- Sits between the keypad scanner and the keypad decoder. All timing is in units of an external tick strobe.

Parameters:
DEPTH, 32, number of stored events (power of 2, >=2)
DUR_W, 12, event duration width in ticks; max duration 2^DUR_W-1
ADDR_W, $clog2(DEPTH), buffer index width (derived, not overridden)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
tick_i  in  1  one-cycle timebase strobe (e.g. 1 kHz)
key_valid_i  in  1  a key is currently held
key_value_i  in  4  scanned key code, meaningful when key_valid_i=1
rec_i  in  1  start-record pulse
play_i  in  1  start-playback pulse
stop_i  in  1  abort/stop pulse
loop_i  in  1  level; 1 = PLAY wraps to event 0 after the last event
key_value_o  out  4  key code to the decoder
mute_o  out  1  1 = rest; downstream gates audio
state_o  out  2  0=IDLE, 1=RECORD, 2=PLAY
count_o  out  ADDR_W+1  number of stored events
full_o  out  1  buffer holds DEPTH events
busy_o  out  1  state_o != IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (rst_ni), fixed by decision.
- Reset values: key_value_o=0, mute_o=1, state_o=IDLE, count_o=0, full_o=0, busy_o=0. Buffer contents are don't-care.
- All outputs are registered.
- Effective key: eff = key_valid_i ? key_value_i : REST. REST is driven as key_value_o=0, mute_o=1.
- Command priority in the same cycle: stop_i > rec_i > play_i.
- rec_i and play_i are accepted only in IDLE. stop_i is accepted in any state.
- IDLE:
  - Outputs track eff with 1-cycle latency: key_value_o=eff code, mute_o=!key_valid_i.
- IDLE -> RECORD on rec_i:
  - count_o and full_o clear.
  - Event duration counter dur=0.
  - The arm flag clears: leading rest before the first key press is not stored.
- RECORD:
  - Outputs pass through as in IDLE.
  - Open event code = eff, latched on arm (first cycle with key_valid_i=1) and on each change of eff.
  - While armed, each tick_i increments dur.
  - Event close: on a change of eff, the open event {code, dur} is written at index count_o if dur>0, and count_o increments. dur=0 events (glitches between ticks) are dropped silently. The new event then opens with dur=0.
  - Saturation: if dur reaches 2^DUR_W-1, the event is written and a new event with the same code opens at dur=0 in the same cycle.
  - Full: the write that makes count_o=DEPTH sets full_o=1 and returns to IDLE next cycle. No further writes occur.
  - stop_i: the open event is written if armed and dur>0 (and not full); then -> IDLE.
- IDLE -> PLAY on play_i, only if count_o>0. If count_o=0, play_i is ignored and the state stays IDLE.
- PLAY:
  - Next cycle: index=0, key_value_o=entry[0].code, mute_o=(entry code is REST), remaining=entry[0].dur.
  - Each tick_i decrements remaining.
  - When tick_i arrives with remaining=1, the next cycle presents entry[index+1]. An event therefore spans exactly dur ticks.
  - After the last event (index=count_o-1): if loop_i=1, wrap to index 0; otherwise -> IDLE with passthrough outputs.
  - loop_i is sampled at the end-of-buffer moment.
  - Live keypad input is ignored during PLAY.
  - stop_i -> IDLE next cycle; outputs revert to passthrough.
  - Buffer and count_o are preserved by PLAY and stop_i. Only rec_i or reset clears them.
- Simultaneous tick_i and an eff change in RECORD: the tick counts toward the closing event, and the new event starts at dur=0.
- Reset mid-operation: immediate return to the reset values, with the buffer logically empty.

Test Plan:
- Reset, then IDLE with key 4'h5 held -> key_value_o=5, mute_o=0 one cycle later. Release the key -> key_value_o=0, mute_o=1.
- rec_i, idle 3 ticks, hold key 1 for 10 ticks, rest 4 ticks, key 8 for 6 ticks, stop_i -> count_o=3 with entries {1,10},{REST,4},{8,6}, state_o=IDLE.
- Play the recording above with loop_i=0 -> key_value_o=1 for exactly 10 ticks, mute_o=1 for 4 ticks, 8 for 6 ticks, then IDLE, busy_o=0. Repeat with loop_i=1 -> key 1 reappears after the 20th tick.
- Record 33 distinct one-tick key changes with DEPTH=32 -> full_o=1, count_o=32, auto return to IDLE, 33rd event not stored. Also: play_i with count_o=0 -> state stays IDLE.
- DUR_W=4: hold key 3 for 20 ticks -> entries {3,15},{3,5}. Toggle keys twice between ticks -> no dur=0 entries stored.
- stop_i asserted in the same cycle as play_i (and separately rec_i with play_i) -> stop wins / rec wins. Assert rst_ni low mid-PLAY -> outputs at reset values asynchronously, count_o=0.
